// File: rtl/sample_sequencer.sv
// Sample-period sequencer: free-running phase counter plus a per-period FSM that
// issues the conv -> lag -> d2s enable pulses, gates them on ready checks and enables the canceller.
module sample_sequencer #(
  parameter int EN_LEN      = 2,
  parameter int CONV_WAIT   = 8,
  parameter int LAG_WAIT    = 600,
  parameter int CANCEL_WAIT = 1250
) (
  input  logic        clk_operation,
  input  logic        rst_n,
  input  logic [12:0] sampling_cycle,
  input  logic        ready_conv,
  input  logic        ready_lag,
  output logic [12:0] sampling_cycle_counter,
  output logic        sampling_light,
  output logic        enable_conv,
  output logic        enable_lag,
  output logic        enable_d2s,
  output logic        enable_sampling,
  output logic        enable_cancel,
  output logic        miss_conv,
  output logic        miss_lag,
  output logic        overrun
);

  localparam int T1_I = EN_LEN + CONV_WAIT;
  localparam int T2_I = T1_I + EN_LEN + LAG_WAIT;
  localparam int T3_I = T2_I + EN_LEN + CANCEL_WAIT + 1;

  localparam logic [12:0] CONV_END = 13'(EN_LEN);
  localparam logic [12:0] T1       = 13'(T1_I);
  localparam logic [12:0] LAG_END  = 13'(T1_I + EN_LEN);
  localparam logic [12:0] T2       = 13'(T2_I);
  localparam logic [12:0] D2S_END  = 13'(T2_I + EN_LEN);
  localparam logic [12:0] HOLD_AT  = 13'(T3_I - 1);
  localparam logic [12:0] P_RESET  = 13'd4000;

  typedef enum logic [2:0] {
    IDLE, CONV, WAIT_CONV, LAG, WAIT_LAG, D2S, WAIT_CANCEL, HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [12:0] period_q;
  logic        wrap;
  logic        conv_check, lag_check;
  logic        conv_d, lag_d, d2s_d, cancel_d, sampling_d;
  logic        miss_conv_d, miss_lag_d, overrun_d;

  function automatic logic [12:0] clamp_period(input logic [12:0] p);
    return (p < 13'd2) ? 13'd2 : p;
  endfunction

  assign wrap       = (sampling_cycle_counter == period_q - 13'd1);
  assign conv_check = (state_q == WAIT_CONV) && (sampling_cycle_counter == T1) && !wrap;
  assign lag_check  = (state_q == WAIT_LAG)  && (sampling_cycle_counter == T2) && !wrap;

  always_ff @(posedge clk_operation or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Windows are keyed to absolute counter values so a failed check keeps the schedule intact
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, HOLD:  if (sampling_cycle_counter == 13'd0) state_d = CONV;
      CONV:        if (sampling_cycle_counter == CONV_END) state_d = WAIT_CONV;
      WAIT_CONV:   if (sampling_cycle_counter == T1) state_d = ready_conv ? LAG : WAIT_LAG;
      LAG:         if (sampling_cycle_counter == LAG_END) state_d = WAIT_LAG;
      WAIT_LAG:    if (sampling_cycle_counter == T2) state_d = ready_lag ? D2S : WAIT_CANCEL;
      D2S:         if (sampling_cycle_counter == D2S_END) state_d = WAIT_CANCEL;
      WAIT_CANCEL: if (sampling_cycle_counter == HOLD_AT) state_d = HOLD;
      default:     state_d = IDLE;
    endcase
    // A wrap before HOLD aborts the sequence; IDLE restarts it from CONV at counter 0
    if (wrap) state_d = (state_q == HOLD) ? HOLD : IDLE;
  end

  always_comb begin
    conv_d      = (state_d == CONV);
    lag_d       = (state_d == LAG);
    d2s_d       = (state_d == D2S);
    cancel_d    = enable_cancel | (state_d == HOLD);
    sampling_d  = enable_sampling | wrap;
    miss_conv_d = miss_conv | (conv_check & ~ready_conv);
    miss_lag_d  = miss_lag | (lag_check & ~ready_lag);
    overrun_d   = overrun | (wrap & (state_q != HOLD));
  end

  always_ff @(posedge clk_operation or negedge rst_n) begin
    if (!rst_n) begin
      sampling_cycle_counter <= 13'd0;
      period_q               <= P_RESET;
      sampling_light         <= 1'b0;
      enable_conv            <= 1'b0;
      enable_lag             <= 1'b0;
      enable_d2s             <= 1'b0;
      enable_sampling        <= 1'b0;
      enable_cancel          <= 1'b0;
      miss_conv              <= 1'b0;
      miss_lag               <= 1'b0;
      overrun                <= 1'b0;
    end else begin
      sampling_cycle_counter <= wrap ? 13'd0 : sampling_cycle_counter + 13'd1;
      if (sampling_cycle_counter == 13'd0) period_q <= clamp_period(sampling_cycle);
      sampling_light         <= wrap;
      enable_conv            <= conv_d;
      enable_lag             <= lag_d;
      enable_d2s             <= d2s_d;
      enable_sampling        <= sampling_d;
      enable_cancel          <= cancel_d;
      miss_conv              <= miss_conv_d;
      miss_lag               <= miss_lag_d;
      overrun                <= overrun_d;
    end
  end

endmodule

// File: tb/tb_sample_sequencer.sv
// Self-checking bench for sample_sequencer: randomized ready/period stimulus compared
// every cycle against a counter-range reference model, plus directed scenario checks.
module tb_sample_sequencer;

  localparam int EN_LEN      = 2;
  localparam int CONV_WAIT   = 8;
  localparam int LAG_WAIT    = 600;
  localparam int CANCEL_WAIT = 1250;
  localparam int T1 = EN_LEN + CONV_WAIT;
  localparam int T2 = T1 + EN_LEN + LAG_WAIT;
  localparam int T3 = T2 + EN_LEN + CANCEL_WAIT + 1;

  logic        clk_operation = 1'b0;
  logic        rst_n = 1'b0;
  logic [12:0] sampling_cycle = 13'd4000;
  logic        ready_conv = 1'b0;
  logic        ready_lag = 1'b0;
  logic [12:0] sampling_cycle_counter;
  logic        sampling_light, enable_conv, enable_lag, enable_d2s;
  logic        enable_sampling, enable_cancel, miss_conv, miss_lag, overrun;

  sample_sequencer #(
    .EN_LEN(EN_LEN), .CONV_WAIT(CONV_WAIT), .LAG_WAIT(LAG_WAIT), .CANCEL_WAIT(CANCEL_WAIT)
  ) dut (
    .clk_operation(clk_operation),
    .rst_n(rst_n),
    .sampling_cycle(sampling_cycle),
    .ready_conv(ready_conv),
    .ready_lag(ready_lag),
    .sampling_cycle_counter(sampling_cycle_counter),
    .sampling_light(sampling_light),
    .enable_conv(enable_conv),
    .enable_lag(enable_lag),
    .enable_d2s(enable_d2s),
    .enable_sampling(enable_sampling),
    .enable_cancel(enable_cancel),
    .miss_conv(miss_conv),
    .miss_lag(miss_lag),
    .overrun(overrun)
  );

  always #5 clk_operation = ~clk_operation;

  int errors = 0;
  int checks = 0;

  // Reference model: period-level facts; pulses derived from counter ranges.
  int m_cnt, m_p;
  bit m_light, m_samp, m_cancel, m_mconv, m_mlag, m_over, m_rc_ok, m_rl_ok;

  task automatic model_reset();
    m_cnt = 0; m_p = 4000;
    m_light = 0; m_samp = 0; m_cancel = 0; m_mconv = 0; m_mlag = 0; m_over = 0;
    m_rc_ok = 0; m_rl_ok = 0;
  endtask

  task automatic check_all(input string tag);
    logic [21:0] obs, exp;
    obs = {sampling_cycle_counter, sampling_light, enable_conv, enable_lag, enable_d2s,
           enable_sampling, enable_cancel, miss_conv, miss_lag, overrun};
    exp = {13'(m_cnt), m_light,
           (m_cnt >= 1 && m_cnt <= EN_LEN),
           (m_rc_ok && m_cnt >= T1 + 1 && m_cnt <= T1 + EN_LEN),
           (m_rl_ok && m_cnt >= T2 + 1 && m_cnt <= T2 + EN_LEN),
           m_samp, m_cancel, m_mconv, m_mlag, m_over};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0t observed=%h expected=%h (cnt,light,conv,lag,d2s,samp,cancel,mconv,mlag,ovr)",
             tag, $time, obs, exp);
    end
  endtask

  task automatic check_val(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag);
    int c, sc;
    bit rc, rl;
    c = m_cnt; rc = ready_conv; rl = ready_lag; sc = int'(sampling_cycle);
    @(posedge clk_operation); #1;
    if (c == m_p - 1) begin
      m_cnt = 0; m_light = 1; m_samp = 1;
      if (m_p <= T3) m_over = 1;
      m_rc_ok = 0; m_rl_ok = 0;
    end else begin
      m_cnt = c + 1; m_light = 0;
      if (c == T1) begin m_rc_ok = rc; if (!rc) m_mconv = 1; end
      if (c == T2) begin m_rl_ok = rl; if (!rl) m_mlag = 1; end
      if (m_cnt == T3) m_cancel = 1;
    end
    if (c == 0) m_p = (sc < 2) ? 2 : sc;
    check_all(tag);
  endtask

  task automatic drive(input bit rc_at, input bit rl_at);
    ready_conv = (m_cnt == T1) ? rc_at : 1'($urandom & 1);
    ready_lag  = (m_cnt == T2) ? rl_at : 1'($urandom & 1);
  endtask

  task automatic run(input int n, input bit rc_at, input bit rl_at, input string tag);
    for (int i = 0; i < n; i++) begin
      drive(rc_at, rl_at);
      step(tag);
    end
  endtask

  // Called at posedge+1: drops rst_n mid-cycle, checks the async clear, releases on negedge.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all(tag);
    @(negedge clk_operation);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk_operation);
    #1 check_all("reset_hold");
    @(negedge clk_operation);
    rst_n = 1'b1;
    #1 check_all("release");

    // Full 4000 period with both readies good at their check cycles
    run(4000, 1'b1, 1'b1, "p4000_ok");
    check_val("wrap_light", 13'(sampling_light), 13'd1);
    check_val("cancel_set", 13'(enable_cancel), 13'd1);
    check_val("flags_clear", {10'd0, miss_conv, miss_lag, overrun}, 13'd0);

    run(4000, 1'b0, 1'b1, "miss_conv");
    check_val("miss_conv_flag", 13'(miss_conv), 13'd1);
    check_val("miss_lag_clear", 13'(miss_lag), 13'd0);

    run(4000, 1'b1, 1'b0, "miss_lag");
    check_val("miss_lag_flag", 13'(miss_lag), 13'd1);

    // Short period: every wrap lands before the canceller point
    sampling_cycle = 13'd1000;
    async_reset("reset_p1000");
    run(3000, 1'b1, 1'b1, "p1000");
    check_val("p1000_overrun", 13'(overrun), 13'd1);
    check_val("p1000_no_cancel", 13'(enable_cancel), 13'd0);

    // Reset while enable_lag is high, then restart
    sampling_cycle = 13'd4000;
    async_reset("reset_p4000");
    run(12, 1'b1, 1'b1, "to_lag");
    check_val("lag_high_at_12", 13'(enable_lag), 13'd1);
    async_reset("reset_mid_lag");
    run(20, 1'b1, 1'b1, "restart");

    // Period change mid-period only applies from the next counter 0
    run(180, 1'b1, 1'b1, "pre_change");
    sampling_cycle = 13'd3000;
    run(3800, 1'b1, 1'b1, "old_period");
    check_val("old_period_wrap", sampling_cycle_counter, 13'd0);
    run(3000, 1'b1, 1'b1, "new_period");
    check_val("new_period_wrap", sampling_cycle_counter, 13'd0);
    check_val("sampling_en", 13'(enable_sampling), 13'd1);

    // Tiny and sub-minimum periods with random ready outcomes
    async_reset("reset_small");
    for (int i = 0; i < 800; i++) begin
      sampling_cycle = 13'($urandom_range(0, 40));
      drive(1'($urandom & 1), 1'($urandom & 1));
      step("small_p");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sample_sequencer.md
SAMPLE_SEQUENCER -- requirements
Module: sample_sequencer

Interface
REQ-001 Parameter EN_LEN, default 2: width in cycles of every enable pulse.
REQ-002 Parameter CONV_WAIT, default 8: idle cycles between the end of enable_conv and the ready_conv check.
REQ-003 Parameter LAG_WAIT, default 600: idle cycles between the end of enable_lag and the ready_lag check.
REQ-004 Parameter CANCEL_WAIT, default 1250: idle cycles between the end of enable_d2s and enable_cancel assertion.
REQ-005 clk_operation  in  1  single clock; all logic on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 sampling_cycle  in  13  period length in cycles, sampled at each wrap.
REQ-008 ready_conv  in  1  level ready from the 16b-to-double converter.
REQ-009 ready_lag  in  1  level ready from the lag generator.
REQ-010 sampling_cycle_counter  out  13  free-running sample-phase counter.
REQ-011 sampling_light  out  1  one-cycle strobe on counter wrap.
REQ-012 enable_conv / enable_lag / enable_d2s  out  1 each  EN_LEN-cycle enable pulses to converter, lag generator, and both double-to-16b converters.
REQ-013 enable_sampling  out  1  level; lag-generator sampling enable.
REQ-014 enable_cancel  out  1  level; echo-canceller enable.
REQ-015 miss_conv / miss_lag / overrun  out  1 each  sticky error flags.

Function
REQ-016 Counter SHALL increment each cycle and load 0 in the cycle after it reads P-1, P = latched sampling_cycle; P latched when counter is 0; values below 2 SHALL be treated as 2.
REQ-017 sampling_light SHALL be 1 exactly in cycles where the counter reads 0 as a result of a wrap (not the first cycle after reset).
REQ-018 enable_sampling SHALL go to 1 with the first sampling_light after reset and stay 1 until reset.
REQ-019 All outputs SHALL be registered; counter-value offsets below refer to the value visible in the same cycle, with defaults in brackets.
REQ-020 FSM states: IDLE, CONV, WAIT_CONV, LAG, WAIT_LAG, D2S, WAIT_CANCEL, HOLD.
REQ-021 IDLE -> CONV when counter reads 0; enable_conv high at counter 1..EN_LEN [1..2].
REQ-022 WAIT_CONV: ready_conv sampled once at T1 = EN_LEN+CONV_WAIT [10]; 1 -> LAG, enable_lag high T1+1..T1+EN_LEN [11..12]; 0 -> miss_conv set, enable_lag suppressed, schedule timing unchanged.
REQ-023 WAIT_LAG: ready_lag sampled once at T2 = T1+EN_LEN+LAG_WAIT [612]; 1 -> D2S, enable_d2s high T2+1..T2+EN_LEN [613..614]; 0 -> miss_lag set, pulse suppressed.
REQ-024 WAIT_CANCEL: enable_cancel SHALL be 1 from counter T3 = T2+EN_LEN+CANCEL_WAIT+1 [1865] onward, regardless of ready results, and stay 1 until reset.
REQ-025 HOLD: no pulses; -> CONV when counter reads 0 (each period repeats REQ-021..024).
REQ-026 ready inputs SHALL be ignored outside their single check cycle.
REQ-027 Wrap while FSM not in HOLD (P <= T3): overrun set, current sequence aborted, all pulses forced low that cycle, new sequence starts from CONV.
REQ-028 Enable pulses SHALL never overlap; each is exactly EN_LEN cycles.
REQ-029 sampling_cycle change mid-period SHALL take effect only at next counter-0.

Reset
REQ-030 rst_n low SHALL immediately force counter 0, P = 4000, FSM IDLE, all enables, sampling_light and flags 0.
REQ-031 rst_n release SHALL start the schedule at the first counter-0 cycle (the first post-reset cycle) without sampling_light.
REQ-032 Reset asserted mid-pulse SHALL drop that pulse asynchronously; no partial pulse after release.

Verification
REQ-033 P=4000, ready_conv=ready_lag=1 -> enable_conv 1..2, enable_lag 11..12, enable_d2s 613..614, enable_cancel from 1865, sampling_light at counter 0 after 3999, flags 0.
REQ-034 ready_conv=0 at counter 10 -> no enable_lag, miss_conv=1, enable_d2s still gated by ready_lag at 612, enable_cancel at 1865.
REQ-035 ready_lag=0 at counter 612, high elsewhere -> no enable_d2s, miss_lag=1, enable_cancel at 1865.
REQ-036 sampling_cycle=1000 -> counter wraps 999->0, overrun=1 at first wrap, enable_cancel never set, enable_conv every 1000 cycles.
REQ-037 rst_n pulsed low at counter 12 (enable_lag high) -> all outputs 0 immediately, restart: enable_conv at counter 1..2 after release.
REQ-038 sampling_cycle changed 4000->3000 at counter 200 -> current period still 4000 cycles, next period 3000; enable_sampling 1 from first wrap.
